div_rem_4bit: RTL and testbench
===============================

// Module: div_rem_4bit
// PURPOSE
//  Sequential restoring divider, the inverse of the 4-bit multiply-accumulate path.
//  Splits a 12-bit value into quotient and remainder so that dividend = quotient*divisor + remainder.
//  Produces one quotient bit per cycle, with a valid/ready handshake on both input and output.
//  Sits beside MAC_4bit in the arithmetic datapath. When quotient < 16, feeding
//  (a=quotient, b=divisor, c=remainder) through MAC_4bit reconstructs the dividend.
// PARAMETERS
//  DW  12  dividend and quotient width
//  VW  4   divisor and remainder width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   dividend/divisor valid
//  in_ready   out  1   block can accept operands
//  dividend   in   DW  unsigned dividend
//  divisor    in   VW  unsigned divisor
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  quotient   out  DW  unsigned quotient
//  remainder  out  VW  unsigned remainder
//  div_zero   out  1   divisor was 0 for this result
// BEHAVIOUR
//  - Reset: rst_n low asynchronously forces
//    - state=IDLE, in_ready=1, out_valid=0
//    - quotient=0, remainder=0, div_zero=0, bit counter=0
//  - FSM states and transitions:
//    - IDLE: in_ready=1. On in_valid&in_ready, latch operands. Go to CALC, or to DONE if divisor==0.
//    - CALC: in_ready=0. Each cycle:
//      - shift the (VW+1)-bit partial remainder left by 1 and bring in the next dividend MSB.
//      - if partial >= divisor: subtract divisor and set quotient bit=1, else set it to 0.
//      - Exactly DW=12 iterations, counter 0..11. After the last iteration go to DONE.
//    - DONE: out_valid=1 and outputs held stable. On out_valid&out_ready go to IDLE.
//  - Latency:
//    - handshake at edge N -> out_valid high after edge N+13 (12 CALC cycles + 1).
//    - divisor==0 -> out_valid high after edge N+1.
//  - Divide by zero: quotient={DW{1'b1}} (12'hFFF), remainder=0, div_zero=1.
//  - Width rules:
//    - partial remainder is VW+1 bits wide (a shifted value is at most 2*divisor-1, i.e. ≤29).
//    - final remainder < divisor, so it fits in VW bits. No overflow is possible.
//  - Flow control:
//    - in_valid while not IDLE is ignored; operands are not queued.
//    - Back-to-back: the cycle after DONE handshakes, in_ready=1. No combinational in_ready from out_ready.
//    - out_ready low holds out_valid, quotient, remainder and div_zero constant indefinitely.
//    - out_ready asserted early (before out_valid) has no effect.
//  - Operand inputs may change freely after the accepting edge; internal copies are used.
//  - Reset mid-CALC or mid-DONE aborts immediately. The pending result is lost and no out_valid pulse is produced.
// STRUCTURE
//  - Shared include mac_defs.vh holds:
//    - DW/VW defaults
//    - FSM encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
//    - DIV0_QUOT constant
//  - One sub-module div_step: combinational restoring step.
//    - inputs: (VW+1)-bit partial, VW-bit divisor
//    - outputs: (VW+1)-bit next partial, 1-bit quotient bit
//    - the subtract is built as a ripple of FA cells with inverted divisor and cin=1
//  - Top level holds the FSM, the 4-bit counter and the shift registers only.
// TESTING
//  1. 200/7 -> quotient=28, remainder=4, div_zero=0. out_valid exactly 13 cycles after accept.
//  2. 4095/15 -> 273 r0. 4095/1 -> 4095 r0. 5/9 -> 0 r5.
//     Checks max dividend, unit divisor and dividend < divisor.
//  3. divisor=0, dividend=1234 -> quotient=12'hFFF, remainder=0, div_zero=1. out_valid 1 cycle after accept.
//  4. Hold out_ready=0 for 20 cycles after out_valid: outputs stable, in_ready=0.
//     In the same window, in_valid pulsed with 99/3: ignored, no extra result.
//  5. Pull rst_n low at CALC cycle 6 of 300/11: all outputs go to reset values at once.
//     After release, 300/11 -> 27 r3.
//  6. Random sweep of 2000 operand pairs with random out_ready.
//     Check q*d + r == dividend and r < d every time.
//     When q < 16, also check MAC_4bit(q, d, r) == dividend.

Source files
------------

// File: rtl/div_rem_4bit_pkg.sv
// div_rem_4bit_pkg
// Shared definitions for the 4-bit restoring divider slice.
//   DW        : dividend / quotient width
//   VW        : divisor / remainder width
//   state_t   : divider FSM encoding (IDLE / CALC / DONE)
//   DIV0_QUOT : quotient reported when the divisor is zero
//   LAST_CNT  : bit-counter value of the final CALC iteration
package div_rem_4bit_pkg;

    localparam int DW = 12;
    localparam int VW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DIV0_QUOT = {DW{1'b1}};
    localparam logic [3:0]    LAST_CNT  = 4'(DW - 1);

endpackage

// File: rtl/div_rem_4bit_step.sv
// div_rem_4bit_step
// One combinational restoring-division step.
//   partial_in  in  VW+1  already-shifted partial remainder
//   divisor     in  VW    divisor
//   partial_out out VW+1  partial remainder after optional subtract
//   q_bit       out 1     quotient bit (1 when partial_in >= divisor)
module div_rem_4bit_step
    import div_rem_4bit_pkg::*;
(
    input  logic [VW:0]   partial_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   partial_out,
    output logic          q_bit
);

    logic [VW:0]   sub_b;
    logic [VW:0]   diff;
    logic [VW+1:0] carry;

    // Two's-complement subtract: add the inverted divisor with carry-in 1.
    // The final carry-out is set exactly when no borrow occurred.
    assign sub_b    = ~{1'b0, divisor};
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i <= VW; i++) begin : g_fa
            assign diff[i]      = partial_in[i] ^ sub_b[i] ^ carry[i];
            assign carry[i + 1] = (partial_in[i] & sub_b[i]) |
                                  (carry[i] & (partial_in[i] ^ sub_b[i]));
        end
    endgenerate

    assign q_bit       = carry[VW+1];
    // Restoring: keep the old partial when the subtract would go negative.
    assign partial_out = q_bit ? diff : partial_in;

endmodule

// File: rtl/div_rem_4bit.sv
// div_rem_4bit
// Sequential restoring divider: dividend = quotient*divisor + remainder,
// one quotient bit per clock, valid/ready handshakes on both sides.
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    operands valid
//   in_ready   out  1    divider can accept operands
//   dividend   in   DW   unsigned dividend
//   divisor    in   VW   unsigned divisor
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   quotient   out  DW   unsigned quotient
//   remainder  out  VW   unsigned remainder
//   div_zero   out  1    divisor was zero for this result
module div_rem_4bit
    import div_rem_4bit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    state_t        state_q,     state_d;
    logic [3:0]    cnt_q,       cnt_d;
    logic [DW-1:0] dvd_q,       dvd_d;
    logic [VW-1:0] dsr_q,       dsr_d;
    logic [VW:0]   part_q,      part_d;
    logic [DW-1:0] quot_q,      quot_d;
    logic [VW-1:0] rem_q,       rem_d;
    logic          div_zero_q,  div_zero_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [VW:0]   step_in;
    logic [VW:0]   step_part;
    logic          step_qbit;

    // The stored partial is always below the divisor, so its top bit is
    // zero and the shifted value fits in VW+1 bits.
    assign step_in = {part_q[VW-1:0], dvd_q[DW-1]};

    div_rem_4bit_step u_step (
        .partial_in  (step_in),
        .divisor     (dsr_q),
        .partial_out (step_part),
        .q_bit       (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        part_d      = part_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_zero_d  = div_zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dsr_d      = divisor;
                    part_d     = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d    = ST_DONE;
                        quot_d     = DIV0_QUOT;
                        rem_d      = '0;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d    = ST_CALC;
                        div_zero_d = 1'b0;
                    end
                end
            end

            ST_CALC: begin
                in_ready_d = 1'b0;
                // Dividend MSB feeds the step; quotient bits shift in at the LSB.
                dvd_d      = {dvd_q[DW-2:0], 1'b0};
                part_d     = step_part;
                quot_d     = {quot_q[DW-2:0], step_qbit};
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    rem_d   = step_part[VW-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_DONE: begin
                // out_valid is registered, so it rises one cycle after entry.
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            part_q      <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            part_q      <= part_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_zero_q  <= div_zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_rem_4bit.sv
// tb_div_rem_4bit
// Directed and randomized checks of the div_rem_4bit divider.
module tb_div_rem_4bit;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] dividend  = '0;
    logic [3:0]  divisor   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] quotient;
    logic [3:0]  remainder;
    logic        div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_rem_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Reference for the neighbouring multiply-accumulate unit: a*b + c.
    function automatic logic [7:0] mac_4bit(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
        return ({4'b0, a} * {4'b0, b}) + {4'b0, c};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present operands for one edge and scramble them.
    task automatic accept_op(input logic [11:0] dvd, input logic [3:0] dsr);
        int k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1)
            $display("[TB] FAIL accept_ready: in_ready=%b required 1", in_ready);
        else
            n_pass++;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        step();
        in_valid = 1'b0;
        dividend = 12'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Count edges after the accepting edge until out_valid rises (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({in_ready, out_valid, div_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 12'd0, 4'd0})
            $display("[TB] FAIL reset_state: rdy=%b vld=%b dz=%b q=%0d r=%0d required rdy=1 vld=0 dz=0 q=0 r=0",
                     in_ready, out_valid, div_zero, quotient, remainder);
        else
            n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    // 200/7 with out_ready already high: early ready must not shortcut anything.
    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        accept_op(12'd200, 4'd7);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL early_ready: out_valid=%b required 0", out_valid);
        else
            n_pass++;
        wait_result(lat);
        n_checks++;
        if (lat != 13)
            $display("[TB] FAIL basic_latency: got %0d required 13", lat);
        else
            n_pass++;
        n_checks++;
        if ({quotient, remainder, div_zero} !== {12'd28, 4'd4, 1'b0})
            $display("[TB] FAIL basic_200_7: q=%0d r=%0d dz=%b required q=28 r=4 dz=0",
                     quotient, remainder, div_zero);
        else
            n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL back_to_back: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        else
            n_pass++;
    endtask

    task automatic test_boundaries();
        logic [11:0] dvds [3] = '{12'd4095, 12'd4095, 12'd5};
        logic [3:0]  dsrs [3] = '{4'd15,    4'd1,     4'd9};
        logic [11:0] qs   [3] = '{12'd273,  12'd4095, 12'd0};
        logic [3:0]  rs   [3] = '{4'd0,     4'd0,     4'd5};
        int lat;
        for (int i = 0; i < 3; i++) begin
            accept_op(dvds[i], dsrs[i]);
            wait_result(lat);
            n_checks++;
            if (lat != 13 || {quotient, remainder, div_zero} !== {qs[i], rs[i], 1'b0})
                $display("[TB] FAIL boundary_%0d/%0d: q=%0d r=%0d dz=%b lat=%0d required q=%0d r=%0d dz=0 lat=13",
                         dvds[i], dsrs[i], quotient, remainder, div_zero, lat, qs[i], rs[i]);
            else
                n_pass++;
            consume();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        accept_op(12'd1234, 4'd0);
        wait_result(lat);
        n_checks++;
        if (lat != 1)
            $display("[TB] FAIL div0_latency: got %0d required 1", lat);
        else
            n_pass++;
        n_checks++;
        if ({quotient, remainder, div_zero} !== {12'hFFF, 4'd0, 1'b1})
            $display("[TB] FAIL div0_result: q=%h r=%0d dz=%b required q=fff r=0 dz=1",
                     quotient, remainder, div_zero);
        else
            n_pass++;
        consume();
    endtask

    // Stall the consumer for 20 cycles and poke in_valid meanwhile.
    task automatic test_hold();
        int lat;
        logic [16:0] snap;
        bit stable = 1'b1;
        bit extra  = 1'b0;
        accept_op(12'd50, 4'd6);
        wait_result(lat);
        snap = {quotient, remainder, div_zero};
        n_checks++;
        if (snap !== {12'd8, 4'd2, 1'b0})
            $display("[TB] FAIL hold_value: q=%0d r=%0d dz=%b required q=8 r=2 dz=0",
                     quotient, remainder, div_zero);
        else
            n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                dividend = 12'd99;
                divisor  = 4'd3;
            end
            step();
            in_valid = 1'b0;
            if ({quotient, remainder, div_zero} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1)
            $display("[TB] FAIL hold_stable: stable=%b required 1", stable);
        else
            n_pass++;
        consume();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL hold_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        else
            n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0)
            $display("[TB] FAIL hold_no_extra: extra_activity=%b required 0", extra);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bit quiet = 1'b1;
        accept_op(12'd300, 4'd11);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, div_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 12'd0, 4'd0})
            $display("[TB] FAIL reset_mid_calc: rdy=%b vld=%b dz=%b q=%0d r=%0d required rdy=1 vld=0 dz=0 q=0 r=0",
                     in_ready, out_valid, div_zero, quotient, remainder);
        else
            n_pass++;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1)
            $display("[TB] FAIL reset_no_pulse: quiet=%b required 1", quiet);
        else
            n_pass++;
        accept_op(12'd300, 4'd11);
        wait_result(lat);
        n_checks++;
        if (lat != 13 || {quotient, remainder, div_zero} !== {12'd27, 4'd3, 1'b0})
            $display("[TB] FAIL after_reset_300_11: q=%0d r=%0d dz=%b lat=%0d required q=27 r=3 dz=0 lat=13",
                     quotient, remainder, div_zero, lat);
        else
            n_pass++;
        consume();
    endtask

    task automatic test_random_sweep();
        int lat;
        logic [11:0] dvd;
        logic [3:0]  dsr;
        logic [23:0] recon;
        bit pre;
        for (int n = 0; n < 2000; n++) begin
            dvd = 12'($urandom_range(0, 4095));
            dsr = 4'($urandom_range(0, 15));
            pre = 1'($urandom_range(0, 1));
            out_ready = pre;
            accept_op(dvd, dsr);
            wait_result(lat);
            n_checks++;
            if (dsr == 4'd0) begin
                if (lat != 1 || {quotient, remainder, div_zero} !== {12'hFFF, 4'd0, 1'b1})
                    $display("[TB] FAIL rand_div0 %0d/0: q=%h r=%0d dz=%b lat=%0d required q=fff r=0 dz=1 lat=1",
                             dvd, quotient, remainder, div_zero, lat);
                else
                    n_pass++;
            end else begin
                recon = {12'd0, quotient} * {20'd0, dsr} + {20'd0, remainder};
                if (lat != 13 || recon !== {12'd0, dvd} || remainder >= dsr || div_zero !== 1'b0)
                    $display("[TB] FAIL rand_div %0d/%0d: q=%0d r=%0d dz=%b lat=%0d required q*d+r=%0d r<d dz=0 lat=13",
                             dvd, dsr, quotient, remainder, div_zero, lat, dvd);
                else
                    n_pass++;
                if (quotient < 12'd16) begin
                    n_checks++;
                    if ({4'd0, mac_4bit(quotient[3:0], dsr, remainder)} !== dvd)
                        $display("[TB] FAIL rand_mac %0d/%0d: mac=%0d required %0d",
                                 dvd, dsr, mac_4bit(quotient[3:0], dsr, remainder), dvd);
                    else
                        n_pass++;
                end
            end
            if (pre) begin
                step();
                out_ready = 1'b0;
            end else begin
                repeat ($urandom_range(0, 3)) step();
                consume();
            end
            n_checks++;
            if (out_valid !== 1'b0)
                $display("[TB] FAIL rand_consume: out_valid=%b required 0", out_valid);
            else
                n_pass++;
        end
    endtask

    // Run every scenario in order and report the tally.
    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_hold();
        test_reset_mid_calc();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
